blink_seq: RTL

Pattern sequencer that sits directly downstream of the blink counter and consumes its one-cycle wrap pulse (`flg`) as a time base. It accepts a blink pattern over a valid/ready handshake and plays it out on `led_out`, one bit per tick. The pattern repeats a programmed number of times, then the block emits a `done` pulse and returns to idle. Its output drives the board LED in place of the counter's raw square wave.

---
 rtl/blink_seq.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/blink_seq.sv
// ---------------------------------------------------------------------------
// blink_seq
// Sequences a blink pattern to the board LED. The time base is the one-cycle
// wrap pulse of the upstream blink counter. A pattern is loaded over a
// valid/ready handshake and is played LSB first, one bit per tick. It plays
// pat_rpt+1 times, then done pulses for one cycle and the block goes idle.
//
// Ports
//   clk        clock
//   rst        asynchronous, active-high reset
//   tick       one-cycle time-base pulse
//   abort      synchronous cancel of playback (ARM/RUN only)
//   pat_valid  pattern offer
//   pat_ready  high in IDLE; pattern accepted when pat_valid & pat_ready
//   pat_data   pattern, bit 0 played first
//   pat_rpt    extra passes (pattern plays pat_rpt+1 times)
//   led_out    registered LED drive
//   busy       high in ARM or RUN
//   done       one-cycle pulse on normal completion
// ---------------------------------------------------------------------------
module blink_seq #(
    parameter int PAT_W = 8,
    parameter int RPT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             abort,
    input  logic             pat_valid,
    output logic             pat_ready,
    input  logic [PAT_W-1:0] pat_data,
    input  logic [RPT_W-1:0] pat_rpt,
    output logic             led_out,
    output logic             busy,
    output logic             done
);

    localparam int IDX_W = $clog2(PAT_W);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAT_W - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARM,
        S_RUN
    } state_t;

    state_t           r_state;
    logic [IDX_W-1:0] r_idx;
    logic [RPT_W-1:0] r_rpt;
    logic [PAT_W-1:0] r_pat;
    logic             r_led;
    logic             r_done;

    state_t           w_state_nxt;
    logic [IDX_W-1:0] w_idx_nxt;
    logic [RPT_W-1:0] w_rpt_nxt;
    logic [PAT_W-1:0] w_pat_nxt;
    logic             w_led_nxt;
    logic             w_done_nxt;
    logic [IDX_W-1:0] w_idx_inc;

    assign w_idx_inc = r_idx + IDX_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_rpt   <= '0;
            r_pat   <= '0;
            r_led   <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_rpt   <= w_rpt_nxt;
            r_pat   <= w_pat_nxt;
            r_led   <= w_led_nxt;
            r_done  <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_rpt_nxt   = r_rpt;
        w_pat_nxt   = r_pat;
        w_led_nxt   = r_led;
        w_done_nxt  = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                // abort is meaningless here and must not block the handshake
                w_led_nxt = 1'b0;
                if (pat_valid) begin
                    w_pat_nxt   = pat_data;
                    w_rpt_nxt   = pat_rpt;
                    w_state_nxt = S_ARM;
                end
            end
            S_ARM: begin
                if (abort) begin
                    w_led_nxt   = 1'b0;
                    w_state_nxt = S_IDLE;
                end else if (tick) begin
                    w_led_nxt   = r_pat[0];
                    w_idx_nxt   = '0;
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (abort) begin
                    w_led_nxt   = 1'b0;
                    w_state_nxt = S_IDLE;
                end else if (tick) begin
                    if (r_idx != LAST_IDX) begin
                        w_idx_nxt = w_idx_inc;
                        w_led_nxt = r_pat[w_idx_inc];
                    end else if (r_rpt != '0) begin
                        // next pass starts on this same tick: no gap
                        w_rpt_nxt = r_rpt - RPT_W'(1);
                        w_idx_nxt = '0;
                        w_led_nxt = r_pat[0];
                    end else begin
                        w_led_nxt   = 1'b0;
                        w_done_nxt  = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: begin
                w_led_nxt   = 1'b0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign pat_ready = (r_state == S_IDLE);
    assign busy      = (r_state != S_IDLE);
    assign led_out   = r_led;
    assign done      = r_done;

endmodule
